// File: rtl/mux_sel_sequencer.sv
// Programmable select-line sequencer: prescaled or manual advance events step a
// channel select through NUM_CH channels in up, down, ping-pong or hold mode.
module mux_sel_sequencer #(
    parameter int SEL_W  = 3,
    parameter int NUM_CH = 8,
    parameter int DIV    = 33554432
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [1:0]       mode,
    input  logic             step,
    input  logic             load,
    input  logic [SEL_W-1:0] load_val,
    output logic [SEL_W-1:0] sel,
    output logic             tick,
    output logic             wrap,
    output logic             dir
);
    localparam int CNT_W = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DIV - 1);
    localparam logic [SEL_W-1:0] SEL_MAX = SEL_W'(NUM_CH - 1);

    typedef enum logic [1:0] {
        MODE_UP   = 2'b00,
        MODE_DOWN = 2'b01,
        MODE_PING = 2'b10,
        MODE_HOLD = 2'b11
    } mode_e;

    mode_e            mode_i;
    logic [SEL_W-1:0] sel_q, sel_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             dir_q, dir_d;
    logic             tick_q, tick_d;
    logic             wrap_q, wrap_d;
    logic             adv;

    assign mode_i = mode_e'(mode);

    always_comb begin
        adv    = 1'b0;
        cnt_d  = cnt_q;
        sel_d  = sel_q;
        dir_d  = (mode_i == MODE_PING) ? dir_q : 1'b0;
        tick_d = 1'b0;
        wrap_d = 1'b0;
        if (load) begin
            // Load wins over step and terminal count; those events are dropped.
            sel_d = (load_val > SEL_MAX) ? SEL_MAX : load_val;
            cnt_d = '0;
            dir_d = 1'b0;
        end else begin
            if (step) begin
                adv   = 1'b1;
                cnt_d = '0;
            end else if (en) begin
                if (cnt_q == CNT_MAX) begin
                    adv   = 1'b1;
                    cnt_d = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            if (adv) begin
                case (mode_i)
                    MODE_UP: begin
                        tick_d = 1'b1;
                        if (sel_q == SEL_MAX) begin
                            sel_d  = '0;
                            wrap_d = 1'b1;
                        end else begin
                            sel_d = sel_q + SEL_W'(1);
                        end
                    end
                    MODE_DOWN: begin
                        tick_d = 1'b1;
                        if (sel_q == '0) begin
                            sel_d  = SEL_MAX;
                            wrap_d = 1'b1;
                        end else begin
                            sel_d = sel_q - SEL_W'(1);
                        end
                    end
                    MODE_PING: begin
                        tick_d = 1'b1;
                        if (!dir_q) begin
                            if (sel_q == SEL_MAX) begin
                                sel_d  = sel_q - SEL_W'(1);
                                dir_d  = 1'b1;
                                wrap_d = 1'b1;
                            end else begin
                                sel_d = sel_q + SEL_W'(1);
                            end
                        end else begin
                            if (sel_q == '0) begin
                                sel_d  = SEL_W'(1);
                                dir_d  = 1'b0;
                                wrap_d = 1'b1;
                            end else begin
                                sel_d = sel_q - SEL_W'(1);
                            end
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sel_q  <= '0;
            cnt_q  <= '0;
            dir_q  <= 1'b0;
            tick_q <= 1'b0;
            wrap_q <= 1'b0;
        end else begin
            sel_q  <= sel_d;
            cnt_q  <= cnt_d;
            dir_q  <= dir_d;
            tick_q <= tick_d;
            wrap_q <= wrap_d;
        end
    end

    assign sel  = sel_q;
    assign tick = tick_q;
    assign wrap = wrap_q;
    assign dir  = dir_q;
endmodule

// File: tb/tb_mux_sel_sequencer.sv
// Directed bench: table of per-cycle vectors on a NUM_CH=5/DIV=4 instance plus a
// hand-written DIV=1 sequence on a NUM_CH=8 instance.
module tb_mux_sel_sequencer;
    typedef struct {
        logic       rst;
        logic       en;
        logic [1:0] mode;
        logic       step;
        logic       load;
        logic [2:0] lv;
        logic [2:0] e_sel;
        logic       e_tick;
        logic       e_wrap;
        logic       e_dir;
        string      name;
    } vec_t;

    logic       clk = 1'b0;
    logic       rst, en, step, load;
    logic [1:0] mode;
    logic [2:0] load_val, sel;
    logic       tick, wrap, dir;

    logic       rst_b, en_b;
    logic [2:0] sel_b;
    logic       tick_b, wrap_b, dir_b;

    int passed = 0;
    int total  = 0;
    vec_t vq[$];

    always #5 clk = ~clk;

    mux_sel_sequencer #(.SEL_W(3), .NUM_CH(5), .DIV(4)) dut (
        .clk(clk), .rst(rst), .en(en), .mode(mode), .step(step), .load(load),
        .load_val(load_val), .sel(sel), .tick(tick), .wrap(wrap), .dir(dir)
    );

    mux_sel_sequencer #(.SEL_W(3), .NUM_CH(8), .DIV(1)) dut_b (
        .clk(clk), .rst(rst_b), .en(en_b), .mode(2'b00), .step(1'b0), .load(1'b0),
        .load_val(3'd0), .sel(sel_b), .tick(tick_b), .wrap(wrap_b), .dir(dir_b)
    );

    function automatic void add(input logic r, input logic e, input logic [1:0] m,
                                input logic s, input logic l, input logic [2:0] lv,
                                input logic [2:0] es, input logic et, input logic ew,
                                input logic ed, input string nm);
        vec_t v;
        v.rst = r; v.en = e; v.mode = m; v.step = s; v.load = l; v.lv = lv;
        v.e_sel = es; v.e_tick = et; v.e_wrap = ew; v.e_dir = ed; v.name = nm;
        vq.push_back(v);
    endfunction

    task automatic check(input string nm, input logic [5:0] act, input logic [5:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got sel/tick/wrap/dir=%b want %b", nm, act, exp);
    endtask

    initial begin
        rst = 1'b1; en = 1'b0; mode = 2'b00; step = 1'b0; load = 1'b0; load_val = 3'd0;
        rst_b = 1'b1; en_b = 1'b0;

        // Up count, prescaled: advance every 4th edge, 4->0 wraps at edge 20.
        add(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, "reset");
        for (int k = 1; k <= 20; k++)
            add(0, 1, 0, 0, 0, 0, 3'((k / 4) % 5), (k % 4) == 0, k == 20, 0, "up_prescaled");
        // Down with manual steps.
        add(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, "reset");
        add(0, 0, 1, 1, 0, 0, 4, 1, 1, 0, "down_wrap");
        add(0, 0, 1, 0, 0, 0, 4, 0, 0, 0, "down_idle");
        add(0, 0, 1, 1, 0, 0, 3, 1, 0, 0, "down_step");
        // Ping-pong 1,2,3,4,3,2,1,0,1.
        add(1, 0, 2, 0, 0, 0, 0, 0, 0, 0, "reset");
        add(0, 0, 2, 1, 0, 0, 1, 1, 0, 0, "pp1");
        add(0, 0, 2, 1, 0, 0, 2, 1, 0, 0, "pp2");
        add(0, 0, 2, 1, 0, 0, 3, 1, 0, 0, "pp3");
        add(0, 0, 2, 1, 0, 0, 4, 1, 0, 0, "pp4");
        add(0, 0, 2, 1, 0, 0, 3, 1, 1, 1, "pp_rev_top");
        add(0, 0, 2, 1, 0, 0, 2, 1, 0, 1, "pp_dn2");
        add(0, 0, 2, 1, 0, 0, 1, 1, 0, 1, "pp_dn1");
        add(0, 0, 2, 1, 0, 0, 0, 1, 0, 1, "pp_dn0");
        add(0, 0, 2, 1, 0, 0, 1, 1, 1, 0, "pp_rev_bot");
        add(0, 0, 2, 1, 0, 0, 2, 1, 0, 0, "pp_up2");
        add(0, 0, 2, 1, 0, 0, 3, 1, 0, 0, "pp_up3");
        add(0, 0, 2, 1, 0, 0, 4, 1, 0, 0, "pp_up4");
        add(0, 0, 2, 1, 0, 0, 3, 1, 1, 1, "pp_rev_top2");
        add(0, 0, 0, 0, 0, 0, 3, 0, 0, 0, "dir_forced_off");
        // Reset while descending, next ping-pong advance gives 1.
        add(0, 0, 2, 1, 0, 0, 4, 1, 0, 0, "pp_up4b");
        add(0, 0, 2, 1, 0, 0, 3, 1, 1, 1, "pp_rev_top3");
        add(1, 0, 2, 1, 0, 0, 0, 0, 0, 0, "rst_mid_pp");
        add(0, 0, 2, 1, 0, 0, 1, 1, 0, 0, "pp_after_rst");
        // Clamped load clears the prescaler.
        add(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, "reset");
        add(0, 1, 0, 0, 0, 0, 0, 0, 0, 0, "pre_cnt1");
        add(0, 1, 0, 0, 0, 0, 0, 0, 0, 0, "pre_cnt2");
        add(0, 1, 0, 0, 1, 7, 4, 0, 0, 0, "load_clamp");
        add(0, 1, 0, 0, 0, 0, 4, 0, 0, 0, "post_load1");
        add(0, 1, 0, 0, 0, 0, 4, 0, 0, 0, "post_load2");
        add(0, 1, 0, 0, 0, 0, 4, 0, 0, 0, "post_load3");
        add(0, 1, 0, 0, 0, 0, 0, 1, 1, 0, "post_load_adv");
        // Load beats step; hold swallows step; step with en low.
        add(0, 0, 0, 1, 1, 2, 2, 0, 0, 0, "load_vs_step");
        add(0, 0, 0, 0, 0, 0, 2, 0, 0, 0, "after_load");
        add(0, 0, 3, 1, 0, 0, 2, 0, 0, 0, "hold_step");
        add(0, 0, 0, 1, 0, 0, 3, 1, 0, 0, "step_en_low");
        // Freeze after 2 counts for 10 cycles, resume: advance 2 edges later.
        add(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, "reset");
        add(0, 1, 0, 0, 0, 0, 0, 0, 0, 0, "frz_cnt1");
        add(0, 1, 0, 0, 0, 0, 0, 0, 0, 0, "frz_cnt2");
        for (int k = 0; k < 10; k++)
            add(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, "frozen");
        add(0, 1, 0, 0, 0, 0, 0, 0, 0, 0, "resume1");
        add(0, 1, 0, 0, 0, 0, 1, 1, 0, 0, "resume_adv");
        // Step on the terminal-count cycle: one advance, prescaler restarts.
        add(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, "reset");
        add(0, 1, 0, 0, 0, 0, 0, 0, 0, 0, "tc_cnt1");
        add(0, 1, 0, 0, 0, 0, 0, 0, 0, 0, "tc_cnt2");
        add(0, 1, 0, 0, 0, 0, 0, 0, 0, 0, "tc_cnt3");
        add(0, 1, 0, 1, 0, 0, 1, 1, 0, 0, "step_at_tc");
        add(0, 1, 0, 0, 0, 0, 1, 0, 0, 0, "tc_after1");
        add(0, 1, 0, 0, 0, 0, 1, 0, 0, 0, "tc_after2");
        add(0, 1, 0, 0, 0, 0, 1, 0, 0, 0, "tc_after3");
        add(0, 1, 0, 0, 0, 0, 2, 1, 0, 0, "tc_after_adv");

        foreach (vq[i]) begin
            rst = vq[i].rst; en = vq[i].en; mode = vq[i].mode;
            step = vq[i].step; load = vq[i].load; load_val = vq[i].lv;
            @(posedge clk); #1;
            check(vq[i].name, {sel, tick, wrap, dir},
                  {vq[i].e_sel, vq[i].e_tick, vq[i].e_wrap, vq[i].e_dir});
        end
        rst = 1'b1; en = 1'b0; step = 1'b0; load = 1'b0;

        // DIV=1, NUM_CH=8: advance every edge, reset at sel=5.
        rst_b = 1'b1; en_b = 1'b0;
        @(posedge clk); #1;
        check("b_reset", {sel_b, tick_b, wrap_b, dir_b}, 6'b000000);
        rst_b = 1'b0; en_b = 1'b1;
        for (int k = 1; k <= 13; k++) begin
            @(posedge clk); #1;
            check("b_div1_up", {sel_b, tick_b, wrap_b, dir_b},
                  {3'(k % 8), 1'b1, (k % 8) == 0, 1'b0});
        end
        rst_b = 1'b1;
        @(posedge clk); #1;
        check("b_rst_at5", {sel_b, tick_b, wrap_b, dir_b}, 6'b000000);
        rst_b = 1'b0;
        @(posedge clk); #1;
        check("b_after_rst", {sel_b, tick_b, wrap_b, dir_b}, {3'd1, 1'b1, 1'b0, 1'b0});

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
